// File: rtl/mem_defs.sv
`default_nettype none
// ============================================================================
// Package     : mem_defs
// Description : MEM-stage shared definitions: controller states, byte-enable
//               constants and the load/store opcodes.
// Revision    : 1.0
// ============================================================================
package mem_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_ALL    = 4'b1111;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;

endpackage
`default_nettype wire

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ctrl
// Description : Turns one MEM-stage load/store request into a single req/ack
//               bus transaction and returns busy, a done pulse and read data.
// Revision    : 1.0
// ============================================================================
module data_ram_ctrl
    import mem_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_ce,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_wdata,
    input  logic [3:0]        ram_byte_sel,
    output logic              ram_busy,
    output logic              ram_done,
    output logic [31:0]       ram_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [ADDR_W-3:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                w_zero_byte_store;
    logic                w_addr_lsb_unused;

    // Byte offset is meaningless on a word bus.
    assign w_addr_lsb_unused = ^ram_addr[1:0];

    // A store with no lanes selected is MEM's misaligned halfword: skip the bus.
    assign w_zero_byte_store = ram_we && (ram_byte_sel == 4'b0000);

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (ram_ce) begin
                    w_state_nxt = w_zero_byte_store ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = bus_ack ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && ram_ce) begin
                r_we    <= ram_we;
                r_addr  <= ram_addr[ADDR_W-1:2];
                r_be    <= ram_we ? ram_byte_sel : BE_ALL;
                r_wdata <= ram_wdata;
            end
            if ((r_state == ST_REQ) && bus_ack && !r_we) begin
                r_rdata <= bus_rdata;
            end
        end
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        ram_busy = 1'b0;
        ram_done = 1'b0;
        bus_req  = 1'b0;
        case (r_state)
            ST_REQ: begin
                ram_busy = 1'b1;
                bus_req  = 1'b1;
            end
            ST_DONE: begin
                ram_done = 1'b1;
            end
            default: begin
                ram_busy = 1'b0;
            end
        endcase
    end

    assign bus_we    = r_we && (r_state == ST_REQ);
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign ram_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_ctrl
// Description : Self-checking bench for data_ram_ctrl: directed scenarios plus
//               randomized loads/stores against a transaction-level model.
// Revision    : 1.0
// ============================================================================
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byte_sel;
    logic        ram_busy;
    logic        ram_done;
    logic [31:0] ram_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_rises = 0;
    int done_pulses = 0;
    int exp_req  = 0;
    int exp_done = 0;
    logic        prev_req = 1'b0;
    logic [31:0] model_rdata;

    data_ram_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_ce       (ram_ce),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_byte_sel (ram_byte_sel),
        .ram_busy     (ram_busy),
        .ram_done     (ram_done),
        .ram_rdata    (ram_rdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus-side activity monitor: counts request rises and done pulses.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (bus_req && !prev_req) req_rises++;
            if (ram_done) done_pulses++;
        end
        prev_req = bus_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One MEM request from an IDLE cycle through its DONE cycle; returns to the
    // caller #1 after the DONE->IDLE edge so the next call issues at once.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int waits, input logic [31:0] rd,
                           input logic hold_ce, output int req_cyc);
        logic       zb;
        logic [3:0] ebe;
        int         cyc0;
        zb  = we && (sel == 4'b0000);
        ebe = we ? sel : 4'b1111;
        req_cyc = -1;
        ram_ce = 1'b1; ram_we = we; ram_addr = addr; ram_wdata = wdata; ram_byte_sel = sel;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        check("idle_busy", ram_busy, 0);
        check("idle_done", ram_done, 0);
        check("idle_req",  bus_req,  0);
        cyc0 = cyc;
        @(posedge clk); #1;
        if (hold_ce) begin
            ram_we = 1'($urandom); ram_addr = $urandom; ram_wdata = $urandom;
            ram_byte_sel = 4'($urandom);
        end else begin
            ram_ce = 1'b0;
        end
        if (!zb) begin
            exp_req++;
            for (int k = 0; k <= waits; k++) begin
                bus_ack   = (k == waits);
                bus_rdata = (k == waits) ? rd : $urandom;
                @(negedge clk);
                if (k == 0) req_cyc = cyc;
                check("req_req",   bus_req,   1);
                check("req_busy",  ram_busy,  1);
                check("req_done",  ram_done,  0);
                check("req_we",    bus_we,    we);
                check("req_addr",  bus_addr,  addr[31:2]);
                check("req_be",    bus_be,    ebe);
                check("req_wdata", bus_wdata, wdata);
                @(posedge clk); #1;
            end
            if (!we) model_rdata = rd;
        end
        exp_done++;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        check("done_done",  ram_done,  1);
        check("done_busy",  ram_busy,  0);
        check("done_req",   bus_req,   0);
        check("done_lat",   cyc - cyc0, zb ? 1 : 2 + waits);
        check("done_rdata", ram_rdata, model_rdata);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        if (hold_ce) ram_ce = 1'b0;
    endtask

    initial begin
        int r1, r2, d0, q0;
        logic        we;
        logic [3:0]  sel;
        rst = 1'b0; ram_ce = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;
        ram_byte_sel = '0; bus_ack = 1'b0; bus_rdata = '0;
        model_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  ram_busy,  0);
        check("rst_done",  ram_done,  0);
        check("rst_req",   bus_req,   0);
        check("rst_we",    bus_we,    0);
        check("rst_addr",  bus_addr,  0);
        check("rst_be",    bus_be,    0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rdata", ram_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Load, zero wait states.
        run_txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, r1);
        check("ld0_rdata", ram_rdata, 32'hDEAD_BEEF);
        // Byte store, 3 wait states; read word untouched.
        run_txn(1'b1, 32'h0000_0013, 32'h5A5A_5A5A, 4'b1000, 3, 32'h0BAD_F00D, 1'b0, r1);
        check("sb_rdata", ram_rdata, 32'hDEAD_BEEF);
        // Zero-byte store skips the bus.
        q0 = req_rises;
        run_txn(1'b1, 32'h0000_0042, 32'h1234_5678, 4'b0000, 0, 32'h0, 1'b0, r1);
        check("zb_noreq", req_rises - q0, 0);
        // ram_ce held through DONE: still a single transaction.
        q0 = req_rises; d0 = done_pulses;
        run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1, r1);
        @(negedge clk);
        check("hold_busy", ram_busy, 0);
        @(posedge clk); #1;
        check("hold_reqs",  req_rises - q0,   1);
        check("hold_dones", done_pulses - d0, 1);
        // Back-to-back loads at the earliest legal issue.
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h1111_1111, 1'b0, r1);
        check("b2b_d1", ram_rdata, 32'h1111_1111);
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h2222_2222, 1'b0, r2);
        check("b2b_d2", ram_rdata, 32'h2222_2222);
        check("b2b_gap", r2 - r1, 4);

        // Randomized mix of loads, stores and zero-byte stores.
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            sel = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_txn(we, $urandom, $urandom, sel, int'($urandom_range(0, 4)), $urandom,
                    1'($urandom), r1);
        end
        check("rnd_reqs",  req_rises,   exp_req);
        check("rnd_dones", done_pulses, exp_done);

        // Reset in the middle of a REQ with no ack.
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, r1);
        ram_ce = 1'b1; ram_we = 1'b0; ram_addr = 32'h0000_0400;
        @(posedge clk); #1;
        ram_ce = 1'b0;
        @(negedge clk);
        check("mid_req", bus_req, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_req",   bus_req,   0);
        check("arst_busy",  ram_busy,  0);
        check("arst_rdata", ram_rdata, 0);
        check("arst_addr",  bus_addr,  0);
        model_rdata = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        d0 = done_pulses;
        repeat (3) begin
            @(negedge clk);
            check("stray_done", ram_done, 0);
            check("stray_req",  bus_req,  0);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("stray_pulses", done_pulses - d0, 0);
        check("stray_rdata",  ram_rdata, model_rdata);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
